// File: rtl/count_uart_tx.sv
// UART transmitter that serialises a counter snapshot taken via valid/ready handshake.
// Define UART_PARITY_EN to add an even-parity bit (8E1); the default build is 8N1.
module count_uart_tx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_param
         $error("count_uart_tx: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic                baud_last;
`ifdef UART_PARITY_EN
   logic                par_q, par_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      ready_d = ready_q;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            // IDLE doubles as the last stop-bit cycle, so busy stays high here
            // until the line is really quiet or the next frame starts.
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            if (data_valid && ready_q) begin
               shift_d = data_in;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
`ifdef UART_PARITY_EN
               par_d   = ^data_in;
`endif
            end
         end
         START: begin
            if (baud_last) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_last) begin
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            // Leave one cycle early: the registered ready is then high in time
            // for an acceptance exactly on the stop bit's final edge.
            if (baud_q == BAUD_PRE) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign data_ready = ready_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed, table-driven bench for count_uart_tx with CLKS_PER_BIT=4.
// Build with UART_PARITY_EN defined to exercise the 8E1 frame.
module tb_count_uart_tx;

   localparam int N = 4;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
   localparam logic [10:0] F_A5 = 11'b10101001010;
   localparam logic [10:0] F_00 = 11'b10000000000;
   localparam logic [10:0] F_FF = 11'b10111111110;
   localparam logic [10:0] F_C3 = 11'b10110000110;
   localparam logic [10:0] F_3C = 11'b10001111000;
   localparam logic [10:0] F_81 = 11'b10100000010;
   localparam logic [10:0] F_07 = 11'b11000001110;
   localparam logic [10:0] F_03 = 11'b10000000110;
`else
   localparam int FB = 10;
   localparam logic [10:0] F_A5 = 11'b01101001010;
   localparam logic [10:0] F_00 = 11'b01000000000;
   localparam logic [10:0] F_FF = 11'b01111111110;
   localparam logic [10:0] F_C3 = 11'b01110000110;
   localparam logic [10:0] F_3C = 11'b01001111000;
   localparam logic [10:0] F_81 = 11'b01100000010;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       tx;
   logic       busy;

   int n_chk;
   int n_fail;
   int cyc;
   int last_acc;
   int prev_acc;

   typedef struct {
      logic [7:0]  d;
      logic [10:0] fr;
      bit          hold;
      bit          idle_after;
   } vec_t;

   vec_t tbl[3];

   count_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .tx         (tx),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Advance one clock; note when the coming edge is a handshake.
   task automatic tick();
      if (rst_n && data_valid && data_ready) begin
         prev_acc = last_acc;
         last_acc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [10:0] fr,
                             input bit hold, input logic [7:0] late);
      data_in    = d;
      data_valid = 1'b1;
      tick();
      for (int c = 0; c < FB * N; c++) begin
         if (c == 0 && !hold) data_valid = 1'b0;
         if (c == 5) data_in = late;
         chk($sformatf("tx[%0h] c=%0d", d, c), tx, fr[c / N]);
         chk($sformatf("busy[%0h] c=%0d", d, c), busy, 1'b1);
         chk($sformatf("ready[%0h] c=%0d", d, c), data_ready, c == FB * N - 1);
         if (c != FB * N - 1) tick();
      end
   endtask

   task automatic idle_check(input string nm);
      tick();
      chk({nm, " idle tx"}, tx, 1'b1);
      chk({nm, " idle busy"}, busy, 1'b0);
      chk({nm, " idle ready"}, data_ready, 1'b1);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; last_acc = 0; prev_acc = 0;
      rst_n = 1'b0; data_valid = 1'b0; data_in = 8'h00;

      tbl[0] = '{d: 8'hA5, fr: F_A5, hold: 1'b0, idle_after: 1'b1};
      tbl[1] = '{d: 8'h00, fr: F_00, hold: 1'b1, idle_after: 1'b0};
      tbl[2] = '{d: 8'hFF, fr: F_FF, hold: 1'b0, idle_after: 1'b1};

      // Reset and idle
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst tx", tx, 1'b1);
         chk("rst busy", busy, 1'b0);
         chk("rst ready", data_ready, 1'b0);
      end
      rst_n = 1'b1;
      #1;
      chk("release ready", data_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle tx", tx, 1'b1);
         chk("idle busy", busy, 1'b0);
         chk("idle ready", data_ready, 1'b1);
      end

      // Single frame, then back-to-back pair with valid held high
      for (int i = 0; i < 3; i++) begin
         send_frame(tbl[i].d, tbl[i].fr, tbl[i].hold, tbl[i].d);
         if (i > 0 && tbl[i-1].hold)
            chk_int("b2b spacing", last_acc - prev_acc, FB * N);
         if (tbl[i].idle_after) idle_check($sformatf("vec%0d", i));
      end

      // data_in changes mid-frame; second byte waits for ready
      send_frame(8'hC3, F_C3, 1'b1, 8'h3C);
      send_frame(8'h3C, F_3C, 1'b0, 8'h3C);
      chk_int("C3->3C spacing", last_acc - prev_acc, FB * N);
      idle_check("3C");

      // Asynchronous reset during data bit 3
      data_in    = 8'hA5;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int c = 0; c < 17; c++) tick();
      chk("pre-reset bit3", tx, 1'b0);
      chk("pre-reset busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async rst tx", tx, 1'b1);
      chk("async rst busy", busy, 1'b0);
      chk("async rst ready", data_ready, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post-rst tx", tx, 1'b1);
      chk("post-rst ready", data_ready, 1'b1);
      send_frame(8'h81, F_81, 1'b0, 8'h81);
      idle_check("81");

`ifdef UART_PARITY_EN
      send_frame(8'h07, F_07, 1'b1, 8'h07);
      send_frame(8'h03, F_03, 1'b0, 8'h03);
      chk_int("parity spacing", last_acc - prev_acc, 44);
      idle_check("03");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
